// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   In-order issue stage in front of the ALU execution unit. Holds one
//   instruction in an issue register, resolves its source operands against a
//   renamed architectural register file (with same-cycle CDB bypass), and
//   offers the command downstream. On acceptance the destination register is
//   renamed to the tag returned by the execution unit. CDB broadcasts retire
//   matching tags back into register values.
//
// Handshakes (both directions use strict valid/ready semantics):
//   - Upstream: an instruction transfers on a rising edge where
//     instr_valid && instr_ready. instr_ready does not depend on instr_valid.
//   - Downstream: command_update_en is the valid. The command transfers on a
//     rising edge where command_update_en && command_update_accepted.
//     command_update_accepted with no command held has no effect.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   instr_*                      upstream instruction and handshake
//   cdb_in_*                     common data bus snoop
//   command_update_en            command valid toward the execution unit
//   operand_{a,b}_data[_is_valid] resolved operands (value or producer tag)
//   command_update_accepted      execution unit took the command
//   command_result_cdb_tag       tag assigned to the accepted command
//   dbg_addr/dbg_data/dbg_busy   combinational register file peek
module alu_issue_unit #(
  parameter int DATA_WIDTH = 4,
  parameter int CDB_TAG_WIDTH = 4,
  parameter int NUM_REGS = 4,
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [REG_ADDR_WIDTH-1:0] instr_dst,
  input  logic [REG_ADDR_WIDTH-1:0] instr_src_a,
  input  logic [REG_ADDR_WIDTH-1:0] instr_src_b,
  input  logic                      instr_b_is_imm,
  input  logic [DATA_WIDTH-1:0]     instr_imm,
  input  logic                      cdb_in_valid,
  input  logic [CDB_TAG_WIDTH-1:0]  cdb_in_tag,
  input  logic [DATA_WIDTH-1:0]     cdb_in_data,
  output logic                      command_update_en,
  output logic [DATA_WIDTH-1:0]     operand_a_data,
  output logic                      operand_a_data_is_valid,
  output logic [DATA_WIDTH-1:0]     operand_b_data,
  output logic                      operand_b_data_is_valid,
  input  logic                      command_update_accepted,
  input  logic [CDB_TAG_WIDTH-1:0]  command_result_cdb_tag,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]     dbg_data,
  output logic                      dbg_busy
);

  // Issue register
  logic                      held_q;
  logic [REG_ADDR_WIDTH-1:0] dst_q;
  logic [REG_ADDR_WIDTH-1:0] src_a_q;
  logic [REG_ADDR_WIDTH-1:0] src_b_q;
  logic                      b_is_imm_q;
  logic [DATA_WIDTH-1:0]     imm_q;

  // Renamed register file
  logic [DATA_WIDTH-1:0]    value_q [NUM_REGS];
  logic [NUM_REGS-1:0]      busy_q;
  logic [CDB_TAG_WIDTH-1:0] tag_q   [NUM_REGS];

  logic fire;
  logic accept;

  assign accept            = held_q && command_update_accepted;
  // The slot frees in the same cycle the command leaves, so issue can run
  // back to back at one instruction per cycle.
  assign instr_ready       = !held_q || command_update_accepted;
  assign fire              = instr_valid && instr_ready;
  assign command_update_en = held_q;

  assign dbg_data = value_q[dbg_addr];
  assign dbg_busy = busy_q[dbg_addr];

  // Resolve one source against pre-update state: value if ready, CDB bypass
  // if the producer broadcasts this cycle, otherwise the producer tag.
  function automatic logic [DATA_WIDTH:0] lookup(input logic [REG_ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH:0] r;
    if (!busy_q[addr]) begin
      r = {1'b1, value_q[addr]};
    end else if (cdb_in_valid && (cdb_in_tag == tag_q[addr])) begin
      r = {1'b1, cdb_in_data};
    end else begin
      r = {1'b0, DATA_WIDTH'(tag_q[addr])};
    end
    return r;
  endfunction

  always_comb begin
    {operand_a_data_is_valid, operand_a_data} = lookup(src_a_q);
    if (b_is_imm_q) begin
      operand_b_data_is_valid = 1'b1;
      operand_b_data          = imm_q;
    end else begin
      {operand_b_data_is_valid, operand_b_data} = lookup(src_b_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q     <= 1'b0;
      dst_q      <= '0;
      src_a_q    <= '0;
      src_b_q    <= '0;
      b_is_imm_q <= 1'b0;
      imm_q      <= '0;
    end else if (fire) begin
      held_q     <= 1'b1;
      dst_q      <= instr_dst;
      src_a_q    <= instr_src_a;
      src_b_q    <= instr_src_b;
      b_is_imm_q <= instr_b_is_imm;
      imm_q      <= instr_imm;
    end else if (accept) begin
      held_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // Only busy registers retire; a stale tag on an idle register is ignored.
        if (cdb_in_valid && busy_q[i] && (tag_q[i] == cdb_in_tag)) begin
          value_q[i] <= cdb_in_data;
          busy_q[i]  <= 1'b0;
        end
        // Rename placed last so a same-cycle rename keeps the register busy
        // under the new tag while the value still captures the broadcast.
        if (accept && (dst_q == REG_ADDR_WIDTH'(i))) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= command_result_cdb_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;
  localparam int DW = 4;
  localparam int TW = 4;
  localparam int NR = 4;
  localparam int AW = 2;
  localparam int CW = 2 * DW + 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [AW-1:0] instr_dst = '0;
  logic [AW-1:0] instr_src_a = '0;
  logic [AW-1:0] instr_src_b = '0;
  logic          instr_b_is_imm = 1'b0;
  logic [DW-1:0] instr_imm = '0;
  logic          cdb_in_valid = 1'b0;
  logic [TW-1:0] cdb_in_tag = '0;
  logic [DW-1:0] cdb_in_data = '0;
  logic          command_update_en;
  logic [DW-1:0] operand_a_data;
  logic          operand_a_data_is_valid;
  logic [DW-1:0] operand_b_data;
  logic          operand_b_data_is_valid;
  logic          command_update_accepted = 1'b0;
  logic [TW-1:0] command_result_cdb_tag = '0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;
  logic          dbg_busy;

  alu_issue_unit #(.DATA_WIDTH(DW), .CDB_TAG_WIDTH(TW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_dst(instr_dst), .instr_src_a(instr_src_a), .instr_src_b(instr_src_b),
    .instr_b_is_imm(instr_b_is_imm), .instr_imm(instr_imm),
    .cdb_in_valid(cdb_in_valid), .cdb_in_tag(cdb_in_tag), .cdb_in_data(cdb_in_data),
    .command_update_en(command_update_en),
    .operand_a_data(operand_a_data), .operand_a_data_is_valid(operand_a_data_is_valid),
    .operand_b_data(operand_b_data), .operand_b_data_is_valid(operand_b_data_is_valid),
    .command_update_accepted(command_update_accepted),
    .command_result_cdb_tag(command_result_cdb_tag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_busy(dbg_busy)
  );

  // Observed command: {a_valid, a_data, b_valid, b_data}
  logic [CW-1:0] cmd_obs;
  assign cmd_obs = {operand_a_data_is_valid, operand_a_data, operand_b_data_is_valid, operand_b_data};

  // Scoreboard
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] exp_cmd;
  int n_checks = 0;
  int n_pass = 0;

  function automatic logic [CW-1:0] mk_cmd(input logic av, input logic [DW-1:0] ad,
                                            input logic bv, input logic [DW-1:0] bd);
    return {av, ad, bv, bd};
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge,
  // outputs are sampled 1 more time unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] dst, input logic [AW-1:0] sa,
                       input logic [AW-1:0] sb, input logic bimm, input logic [DW-1:0] imm);
    instr_valid    = 1'b1;
    instr_dst      = dst;
    instr_src_a    = sa;
    instr_src_b    = sb;
    instr_b_is_imm = bimm;
    instr_imm      = imm;
  endtask

  task automatic pop_exp();
    if (exp_q.size() == 0) exp_cmd = '1;
    else exp_cmd = exp_q.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    n_checks++;
    if (command_update_en !== 1'b0) $display("FAIL reset_en got %b exp 0", command_update_en);
    else n_pass++;
    n_checks++;
    if (instr_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", instr_ready);
    else n_pass++;
    // Acceptance with nothing held must not rename anything.
    command_update_accepted = 1'b1;
    command_result_cdb_tag  = 4'd7;
    next_cycle();
    command_update_accepted = 1'b0;
    for (int i = 0; i < NR; i++) begin
      dbg_addr = AW'(i);
      #1;
      n_checks++;
      if ({dbg_busy, dbg_data} !== 5'b0)
        $display("FAIL reset_reg%0d got busy=%b data=%0d exp busy=0 data=0", i, dbg_busy, dbg_data);
      else n_pass++;
    end
  endtask

  task automatic test_basic_issue();
    offer(2'd1, 2'd0, 2'd2, 1'b0, 4'd0);
    exp_q.push_back(mk_cmd(1'b1, 4'd0, 1'b1, 4'd0));
    next_cycle();
    instr_valid = 1'b0;
    #1;
    n_checks++;
    if (command_update_en !== 1'b1) $display("FAIL basic_en got %b exp 1", command_update_en);
    else n_pass++;
    pop_exp();
    n_checks++;
    if (cmd_obs !== exp_cmd) $display("FAIL basic_cmd got %h exp %h", cmd_obs, exp_cmd);
    else n_pass++;
    command_update_accepted = 1'b1;
    command_result_cdb_tag  = 4'd3;
    next_cycle();
    command_update_accepted = 1'b0;
    dbg_addr = 2'd1;
    #1;
    n_checks++;
    if ({command_update_en, dbg_busy} !== 2'b01)
      $display("FAIL basic_rename got en=%b busy=%b exp en=0 busy=1", command_update_en, dbg_busy);
    else n_pass++;
  endtask

  task automatic test_cdb_bypass();
    // reg1 busy tag 3; operand B from immediate regardless of src_b
    offer(2'd3, 2'd1, 2'd1, 1'b1, 4'd5);
    exp_q.push_back(mk_cmd(1'b0, 4'd3, 1'b1, 4'd5));
    exp_q.push_back(mk_cmd(1'b1, 4'd9, 1'b1, 4'd5));
    next_cycle();
    instr_valid = 1'b0;
    #1;
    pop_exp();
    n_checks++;
    if (cmd_obs !== exp_cmd) $display("FAIL bypass_pending got %h exp %h", cmd_obs, exp_cmd);
    else n_pass++;
    cdb_in_valid = 1'b1;
    cdb_in_tag   = 4'd3;
    cdb_in_data  = 4'd9;
    command_update_accepted = 1'b1;
    command_result_cdb_tag  = 4'd6;
    #1;
    pop_exp();
    n_checks++;
    if (cmd_obs !== exp_cmd) $display("FAIL bypass_same_cycle got %h exp %h", cmd_obs, exp_cmd);
    else n_pass++;
    next_cycle();
    cdb_in_valid = 1'b0;
    command_update_accepted = 1'b0;
    dbg_addr = 2'd1;
    #1;
    n_checks++;
    if ({dbg_busy, dbg_data} !== {1'b0, 4'd9})
      $display("FAIL bypass_retire got busy=%b data=%0d exp busy=0 data=9", dbg_busy, dbg_data);
    else n_pass++;
    dbg_addr = 2'd3;
    #1;
    n_checks++;
    if (dbg_busy !== 1'b1) $display("FAIL bypass_rename3 got %b exp 1", dbg_busy);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [CW-1:0] first_cmd;
    offer(2'd0, 2'd1, 2'd3, 1'b0, 4'd0);
    exp_q.push_back(mk_cmd(1'b1, 4'd9, 1'b0, 4'd6));
    next_cycle();
    // A second instruction waits at the input while the first stalls.
    offer(2'd2, 2'd1, 2'd1, 1'b0, 4'd0);
    pop_exp();
    first_cmd = exp_cmd;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if ({instr_ready, command_update_en, cmd_obs} !== {1'b0, 1'b1, first_cmd})
        $display("FAIL stall_c%0d got rdy=%b en=%b cmd=%h exp rdy=0 en=1 cmd=%h",
                 c, instr_ready, command_update_en, cmd_obs, first_cmd);
      else n_pass++;
      next_cycle();
    end
    command_update_accepted = 1'b1;
    command_result_cdb_tag  = 4'd5;
    #1;
    n_checks++;
    if (instr_ready !== 1'b1) $display("FAIL stall_release_ready got %b exp 1", instr_ready);
    else n_pass++;
    exp_q.push_back(mk_cmd(1'b1, 4'd9, 1'b1, 4'd9));
    next_cycle();
    // Back-to-back: accept dst2 as tag 1 while the next instruction issues.
    command_update_accepted = 1'b1;
    command_result_cdb_tag  = 4'd1;
    offer(2'd2, 2'd2, 2'd0, 1'b0, 4'd0);
    #1;
    pop_exp();
    n_checks++;
    if ({command_update_en, cmd_obs} !== {1'b1, exp_cmd})
      $display("FAIL b2b_first got en=%b cmd=%h exp en=1 cmd=%h", command_update_en, cmd_obs, exp_cmd);
    else n_pass++;
    exp_q.push_back(mk_cmd(1'b0, 4'd1, 1'b0, 4'd5));
    next_cycle();
    instr_valid = 1'b0;
    command_result_cdb_tag = 4'd4;
    #1;
    pop_exp();
    n_checks++;
    if ({command_update_en, cmd_obs} !== {1'b1, exp_cmd})
      $display("FAIL b2b_second got en=%b cmd=%h exp en=1 cmd=%h", command_update_en, cmd_obs, exp_cmd);
    else n_pass++;
    next_cycle();
    command_update_accepted = 1'b0;
  endtask

  task automatic test_stale_tag();
    // reg2 renamed tag1 then tag4; a broadcast of tag1 is stale.
    cdb_in_valid = 1'b1;
    cdb_in_tag   = 4'd1;
    cdb_in_data  = 4'd7;
    next_cycle();
    cdb_in_valid = 1'b0;
    dbg_addr = 2'd2;
    #1;
    n_checks++;
    if ({dbg_busy, dbg_data} !== {1'b1, 4'd0})
      $display("FAIL stale_tag got busy=%b data=%0d exp busy=1 data=0", dbg_busy, dbg_data);
    else n_pass++;
  endtask

  task automatic test_rename_snoop_same_cycle();
    // reg0 busy tag5, reg2 busy tag4
    offer(2'd0, 2'd0, 2'd2, 1'b0, 4'd0);
    exp_q.push_back(mk_cmd(1'b0, 4'd5, 1'b0, 4'd4));
    exp_q.push_back(mk_cmd(1'b1, 4'd6, 1'b0, 4'd4));
    next_cycle();
    instr_valid = 1'b0;
    #1;
    pop_exp();
    n_checks++;
    if (cmd_obs !== exp_cmd) $display("FAIL rs_pending got %h exp %h", cmd_obs, exp_cmd);
    else n_pass++;
    command_update_accepted = 1'b1;
    command_result_cdb_tag  = 4'd2;
    cdb_in_valid = 1'b1;
    cdb_in_tag   = 4'd5;
    cdb_in_data  = 4'd6;
    #1;
    pop_exp();
    n_checks++;
    if (cmd_obs !== exp_cmd) $display("FAIL rs_bypass got %h exp %h", cmd_obs, exp_cmd);
    else n_pass++;
    next_cycle();
    command_update_accepted = 1'b0;
    cdb_in_valid = 1'b0;
    dbg_addr = 2'd0;
    #1;
    n_checks++;
    if ({dbg_busy, dbg_data} !== {1'b1, 4'd6})
      $display("FAIL rs_reg0 got busy=%b data=%0d exp busy=1 data=6", dbg_busy, dbg_data);
    else n_pass++;
    // New tag 2 must be the one that retires reg0.
    cdb_in_valid = 1'b1;
    cdb_in_tag   = 4'd2;
    cdb_in_data  = 4'd8;
    next_cycle();
    cdb_in_valid = 1'b0;
    #1;
    n_checks++;
    if ({dbg_busy, dbg_data} !== {1'b0, 4'd8})
      $display("FAIL rs_newtag got busy=%b data=%0d exp busy=0 data=8", dbg_busy, dbg_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    offer(2'd1, 2'd1, 2'd1, 1'b0, 4'd0);
    next_cycle();
    instr_valid = 1'b0;
    #1;
    n_checks++;
    if (command_update_en !== 1'b1) $display("FAIL rst_stall_held got %b exp 1", command_update_en);
    else n_pass++;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({command_update_en, instr_ready} !== 2'b01)
      $display("FAIL rst_stall_out got en=%b rdy=%b exp en=0 rdy=1", command_update_en, instr_ready);
    else n_pass++;
    for (int i = 0; i < NR; i++) begin
      dbg_addr = AW'(i);
      #1;
      n_checks++;
      if ({dbg_busy, dbg_data} !== 5'b0)
        $display("FAIL rst_stall_reg%0d got busy=%b data=%0d exp busy=0 data=0", i, dbg_busy, dbg_data);
      else n_pass++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_issue();
    test_cdb_bypass();
    test_stall();
    test_stale_tag();
    test_rename_snoop_same_cycle();
    test_reset_mid_stall();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
